vec_data_mem_ctrl: RTL and testbench
====================================

Name: vec_data_mem_ctrl

Overview:
- Data-memory responder for the vector/scalar CPU's load/store port; it is the memory side of the addr / dataWrite_i / dataRead_i / memWrite / vec_scalar interface.
- Backs a single-ported 32-bit synchronous RAM. A vector access (16 words) is serialised through an access FSM, one word per cycle.
- Scalar accesses use lane 15 only, matching the CPU's scalar lane.
- Exposes busy/rdValid/wrDone so the pipeline can stall until the access completes.

Parameters:
AW, 13, word-address width; memory depth is 2**AW words.
DW, 32, data word width.
LANES, 16, vector lanes per access.

Ports:
clk  in  1  clock
rst  in  1  reset
req  in  1  access request, sampled only when busy=0
memWrite  in  1  1=store, 0=load (qualified by req)
vec_scalar  in  1  1=vector (LANES words), 0=scalar (1 word)
addr  in  AW  base word address
dataWrite_i  in  LANES x DW  store data, lane 15 = word at addr
dataRead_i  out  LANES x DW  load result, registered, held until next load completes
busy  out  1  access in progress (registered)
rdValid  out  1  one-cycle pulse: dataRead_i just updated
wrDone  out  1  one-cycle pulse: store fully committed

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, rdValid=0, wrDone=0, dataRead_i=0, idx=0. RAM contents are not cleared.
- Accept: accept = req & (state==IDLE). On accept, latch addr→base, memWrite, vec_scalar and dataWrite_i→wbuf. Set n = vec_scalar ? LANES : 1.
- Ignored requests: req while busy=1 is ignored and not queued.
- Lane mapping: element idx (0..n-1) ↔ RAM[(base+idx) mod 2**AW] ↔ lane 15-idx.
- Wrap-around: address arithmetic is AW bits wide and wraps silently. Example: base=8190 vector touches 8190, 8191, 0, …, 13.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on accept go to ACCESS with idx=0; otherwise stay in IDLE.
- ACCESS, store: each cycle write RAM[base+idx] = wbuf[15-idx]. If idx==n-1 go to IDLE and assert wrDone next cycle; otherwise idx++.
- ACCESS, load: each cycle issue a read of RAM[base+idx]. The RAM has 1-cycle read latency, so the word issued at idx is captured into rbuf[15-idx] on the following edge. If idx==n-1 go to RESP; otherwise idx++.
- RESP: capture the last word, then dataRead_i <= rbuf (full vector). Lanes not written by a scalar load are 0. Assert rdValid for the next cycle and go to IDLE.
- rbuf is cleared on accept of a load.
- busy = (state != IDLE), registered.
- Latency from req in cycle 0:
  - Scalar store: busy in cycle 1; RAM updated at end of cycle 1; wrDone in cycle 2.
  - Vector store: busy in cycles 1–16; wrDone in cycle 17.
  - Scalar load: busy in cycles 1–2; rdValid and new dataRead_i in cycle 3.
  - Vector load: busy in cycles 1–17; rdValid in cycle 18.
- Back-to-back: busy=0 in the rdValid/wrDone cycle, so a req in that cycle is accepted. There are no idle bubbles beyond that.
- Read-after-write: accesses are strictly serialised, so a load issued after a store always returns the stored data.
- dataWrite_i may change after accept without effect (wbuf is used).
- Reset mid-operation: the FSM aborts to IDLE. Store words already written stay in RAM. No rdValid/wrDone is produced, and dataRead_i is cleared to 0.
- rdValid and wrDone are never asserted in the same cycle.

Test Plan:
- Scalar store/load: store addr=5, lane15=0xDEADBEEF; then load scalar addr=5 → rdValid 3 cycles after req, dataRead_i[15]=0xDEADBEEF, lanes 14..0 = 0.
- Vector store/load: store addr=100, lane k = 0x1000+k; then vector load addr=100 → rdValid 18 cycles after req, dataRead_i lane k = 0x1000+k; scalar load addr=115 returns lane15=0x1000.
- Wrap-around: vector store at addr=8190 → RAM[8190]=lane15, RAM[8191]=lane14, RAM[0]=lane13; a scalar load at addr 0 returns the lane13 value.
- Busy rejection: req asserted every cycle during a vector load with a different addr → only the first is serviced; the second is accepted in the rdValid cycle; busy is high for exactly 17 cycles per vector load.
- Reset mid-access: assert rst in cycle 8 of a vector store to addr=200 → busy=0, wrDone never pulses, dataRead_i=0; a subsequent vector load shows words 200..206 written, 207..215 unchanged.
- Back-to-back: scalar store to 7 = 0x55, then scalar load of 7 issued in the wrDone cycle → rdValid with lane15=0x55 three cycles later.

Source files
------------

// File: rtl/vec_data_mem_ctrl.sv
// rtl/vec_data_mem_ctrl.sv - Data-memory responder serialising scalar/vector load-store accesses onto a single-port RAM.
module vec_data_mem_ctrl #(
    parameter int AW    = 13,
    parameter int DW    = 32,
    parameter int LANES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  memWrite,
    input  logic                  vec_scalar,
    input  logic [AW-1:0]         addr,
    input  logic [LANES*DW-1:0]   dataWrite_i,
    output logic [LANES*DW-1:0]   dataRead_i,
    output logic                  busy,
    output logic                  rdValid,
    output logic                  wrDone
);
    localparam int IW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                     state, nextState;
    logic [AW-1:0]              base;
    logic                       isWrite, isVec;
    logic [IW-1:0]              idx;
    logic [LANES-1:0][DW-1:0]   wbuf, rbuf, rbufFinal;
    logic [DW-1:0]              mem [0:(1<<AW)-1];
    logic [DW-1:0]              ramQ;
    logic                       accept, lastIdx, ramWe;
    logic [AW-1:0]              ramAddr;
    logic [IW-1:0]              laneSel, prevLane;

    assign accept   = req & (state == IDLE);
    assign lastIdx  = isVec ? (idx == IW'(LANES-1)) : (idx == '0);
    assign ramAddr  = base + AW'(idx);
    assign laneSel  = IW'(LANES-1) - idx;
    assign prevLane = laneSel + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        ramWe     = 1'b0;
        case (state)
            IDLE:   if (accept) nextState = ACCESS;
            ACCESS: begin
                ramWe = isWrite;
                if (lastIdx) nextState = isWrite ? IDLE : RESP;
            end
            RESP:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The last issued word is still in ramQ during RESP; it belongs to lane LANES-n.
    always_comb begin
        rbufFinal = rbuf;
        rbufFinal[isVec ? IW'(0) : IW'(LANES-1)] = ramQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            isWrite    <= 1'b0;
            isVec      <= 1'b0;
            idx        <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            dataRead_i <= '0;
            busy       <= 1'b0;
            rdValid    <= 1'b0;
            wrDone     <= 1'b0;
        end else begin
            rdValid <= 1'b0;
            wrDone  <= 1'b0;
            busy    <= (nextState != IDLE);
            case (state)
                IDLE: if (accept) begin
                    base    <= addr;
                    isWrite <= memWrite;
                    isVec   <= vec_scalar;
                    wbuf    <= dataWrite_i;
                    idx     <= '0;
                    if (!memWrite) rbuf <= '0;
                end
                ACCESS: begin
                    // Read data arrives one cycle after issue, so capture the previous element.
                    if (!isWrite && idx != '0) rbuf[prevLane] <= ramQ;
                    if (lastIdx) begin
                        if (isWrite) wrDone <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                RESP: begin
                    dataRead_i <= rbufFinal;
                    rdValid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe && !rst) mem[ramAddr] <= wbuf[laneSel];
        ramQ <= mem[ramAddr];
    end
endmodule

// File: tb/tb_vec_data_mem_ctrl.sv
// tb/tb_vec_data_mem_ctrl.sv - Self-checking bench for vec_data_mem_ctrl against a word-array memory model.
module tb_vec_data_mem_ctrl;
    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          memWrite;
    logic          vec_scalar;
    logic [12:0]   addr;
    logic [511:0]  dataWrite_i;
    logic [511:0]  dataRead_i;
    logic          busy, rdValid, wrDone;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl   [8192];
    bit          known [8192];

    vec_data_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .memWrite(memWrite), .vec_scalar(vec_scalar),
        .addr(addr), .dataWrite_i(dataWrite_i), .dataRead_i(dataRead_i),
        .busy(busy), .rdValid(rdValid), .wrDone(wrDone)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected load result and which lanes are comparable, built from the memory model.
    task automatic expect_load(input bit vec, input logic [12:0] a,
                               output logic [511:0] exp, output logic [511:0] mask);
        logic [12:0] ai;
        exp  = '0;
        mask = '1;
        for (int i = 0; i < (vec ? 16 : 1); i++) begin
            ai = a + 13'(i);
            exp[(15-i)*32 +: 32] = mdl[ai];
            if (!known[ai]) mask[(15-i)*32 +: 32] = '0;
        end
    endtask

    task automatic access(input bit wr, input bit vec, input logic [12:0] a, input logic [511:0] wd);
        int          expLat, busyCnt, doneCyc;
        bit          done;
        logic [511:0] exp, mask;
        logic [12:0] ai;
        expLat = wr ? (vec ? 17 : 2) : (vec ? 18 : 3);
        expect_load(vec, a, exp, mask);
        if (wr) begin
            for (int i = 0; i < (vec ? 16 : 1); i++) begin
                ai = a + 13'(i);
                mdl[ai]   = wd[(15-i)*32 +: 32];
                known[ai] = 1'b1;
            end
        end
        req = 1'b1; memWrite = wr; vec_scalar = vec; addr = a; dataWrite_i = wd;
        tick;
        req = 1'b0;
        dataWrite_i = rand_vec();
        addr = 13'($urandom);
        done = 1'b0; busyCnt = 0; doneCyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (rdValid || wrDone) begin
                done = 1'b1; doneCyc = c;
                break;
            end
            if (busy) busyCnt++;
            tick;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout wr=%0d vec=%0d addr=%0d: no completion pulse within 40 cycles", wr, vec, a);
            return;
        end
        total++;
        if (doneCyc !== expLat) begin
            bad++;
            $display("FAIL latency wr=%0d vec=%0d: got %0d want %0d", wr, vec, doneCyc, expLat);
        end
        total++;
        if (busyCnt !== expLat - 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_cycles wr=%0d vec=%0d: got %0d (busy at done=%0b) want %0d", wr, vec, busyCnt, busy, expLat - 1);
        end
        total++;
        if (rdValid !== !wr || wrDone !== wr) begin
            bad++;
            $display("FAIL pulse_kind wr=%0d: got rdValid=%0b wrDone=%0b", wr, rdValid, wrDone);
        end
        if (!wr) begin
            total++;
            if ((dataRead_i & mask) !== (exp & mask)) begin
                bad++;
                $display("FAIL load_data vec=%0d addr=%0d: got %h want %h", vec, a, dataRead_i & mask, exp & mask);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; memWrite = 1'b0; vec_scalar = 1'b0; addr = '0; dataWrite_i = '0;
        repeat (3) tick;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || rdValid !== 1'b0 || wrDone !== 1'b0 || dataRead_i !== '0) begin
            bad++;
            $display("FAIL reset_state: got busy=%0b rdValid=%0b wrDone=%0b data=%h want all 0", busy, rdValid, wrDone, dataRead_i);
        end
    endtask

    task automatic test_scalar;
        logic [511:0] wd;
        wd = rand_vec();
        wd[15*32 +: 32] = 32'hDEADBEEF;
        access(1'b1, 1'b0, 13'd5, wd);
        access(1'b0, 1'b0, 13'd5, '0);
        total++;
        if (dataRead_i !== {32'hDEADBEEF, 480'h0}) begin
            bad++;
            $display("FAIL scalar_lane15: got %h want deadbeef in lane 15 only", dataRead_i);
        end
    endtask

    task automatic test_vector;
        logic [511:0] wd;
        for (int k = 0; k < 16; k++) wd[k*32 +: 32] = 32'h1000 + k;
        access(1'b1, 1'b1, 13'd100, wd);
        access(1'b0, 1'b1, 13'd100, '0);
        access(1'b0, 1'b0, 13'd115, '0);
        total++;
        if (dataRead_i[15*32 +: 32] !== 32'h1000) begin
            bad++;
            $display("FAIL scalar_115: got %h want 00001000", dataRead_i[15*32 +: 32]);
        end
    endtask

    task automatic test_wrap;
        logic [511:0] wd;
        wd = rand_vec();
        access(1'b1, 1'b1, 13'd8190, wd);
        access(1'b0, 1'b0, 13'd0, '0);
        total++;
        if (dataRead_i[15*32 +: 32] !== wd[13*32 +: 32]) begin
            bad++;
            $display("FAIL wrap_addr0: got %h want %h", dataRead_i[15*32 +: 32], wd[13*32 +: 32]);
        end
        access(1'b0, 1'b1, 13'd8190, '0);
    endtask

    task automatic test_busy_reject;
        logic [511:0] exp, mask;
        int  busyCnt, doneCyc;
        bit  got;
        expect_load(1'b1, 13'd100, exp, mask);
        req = 1'b1; memWrite = 1'b0; vec_scalar = 1'b1; addr = 13'd100;
        tick;
        vec_scalar = 1'b0; addr = 13'd5;
        busyCnt = 0; got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (rdValid) begin got = 1'b1; break; end
            if (busy) busyCnt++;
            tick;
        end
        total++;
        if (!got || busyCnt !== 17 || dataRead_i !== exp) begin
            bad++;
            $display("FAIL busy_reject_first: got done=%0b busy=%0d data=%h want busy=17 data=%h", got, busyCnt, dataRead_i, exp);
        end
        tick;
        req = 1'b0;
        got = 1'b0; doneCyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (rdValid) begin got = 1'b1; doneCyc = c; break; end
            tick;
        end
        total++;
        if (!got || doneCyc !== 3 || dataRead_i !== {mdl[5], 480'h0}) begin
            bad++;
            $display("FAIL busy_reject_second: got done=%0b cyc=%0d data=%h want cyc=3 lane15=%h", got, doneCyc, dataRead_i, mdl[5]);
        end
    endtask

    task automatic test_reset_mid;
        logic [511:0] wd;
        bit sawDone;
        access(1'b1, 1'b1, 13'd200, rand_vec());
        wd = rand_vec();
        req = 1'b1; memWrite = 1'b1; vec_scalar = 1'b1; addr = 13'd200; dataWrite_i = wd;
        tick;
        req = 1'b0;
        sawDone = wrDone;
        for (int c = 2; c <= 8; c++) begin
            tick;
            sawDone |= wrDone;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) mdl[200 + i] = wd[(15-i)*32 +: 32];
        total++;
        if (busy !== 1'b0 || dataRead_i !== '0 || wrDone !== 1'b0 || rdValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got busy=%0b wrDone=%0b rdValid=%0b data=%h want 0", busy, wrDone, rdValid, dataRead_i);
        end
        repeat (20) begin
            tick;
            sawDone |= wrDone;
        end
        total++;
        if (sawDone) begin
            bad++;
            $display("FAIL reset_mid_wrdone: got wrDone pulse want none");
        end
        access(1'b0, 1'b1, 13'd200, '0);
    endtask

    task automatic test_back_to_back;
        logic [511:0] wd;
        wd = '0;
        wd[15*32 +: 32] = 32'h55;
        access(1'b1, 1'b0, 13'd7, wd);
        access(1'b0, 1'b0, 13'd7, '0);
        total++;
        if (dataRead_i[15*32 +: 32] !== 32'h55) begin
            bad++;
            $display("FAIL back_to_back: got %h want 00000055", dataRead_i[15*32 +: 32]);
        end
    endtask

    task automatic test_random;
        access(1'b1, 1'b1, 13'd300, rand_vec());
        access(1'b1, 1'b1, 13'd316, rand_vec());
        access(1'b1, 1'b1, 13'd332, rand_vec());
        for (int n = 0; n < 24; n++) begin
            access(1'($urandom), 1'($urandom), 13'(300 + $urandom_range(0, 32)), rand_vec());
        end
    endtask

    initial begin
        test_reset;
        test_scalar;
        test_vector;
        test_wrap;
        test_busy_reject;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
